// File: rtl/dsram_pkg.sv
// Shared definitions for the data-side sram responder: size codes, queue entry layout, queue depth.
package dsram_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;
  localparam int QDEPTH = 2;
  localparam int OCC_W  = 2;

  typedef struct packed {
    logic              is_wr;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } q_entry_t;

endpackage

// File: rtl/dsram_responder_resp_fifo.sv
// Two-entry in-order response queue; every entry counts down to its response cycle.
module resp_fifo
  import dsram_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              push_is_wr,
  input  logic [DATA_W-1:0] push_data,
  output logic              head_ready,
  output logic              head_is_wr,
  output logic [DATA_W-1:0] head_data,
  output logic [OCC_W-1:0]  occupancy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  q_entry_t q_reg   [QDEPTH];
  q_entry_t q_next  [QDEPTH];
  q_entry_t aged    [QDEPTH];
  logic [QDEPTH-1:0] valid_reg;
  logic [QDEPTH-1:0] valid_next;
  q_entry_t push_entry;
  logic pop;

  assign head_ready = valid_reg[0] && (q_reg[0].cnt == '0);
  assign pop        = head_ready;
  assign head_is_wr = q_reg[0].is_wr;
  assign head_data  = q_reg[0].data;
  assign occupancy  = OCC_W'(valid_reg[0]) + OCC_W'(valid_reg[1]);

  assign push_entry = '{is_wr: push_is_wr, data: push_data, cnt: CNT_INIT};

  // Age first, then shift on pop, then place the new entry in the first free slot.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      aged[i] = q_reg[i];
      if (q_reg[i].cnt != '0) aged[i].cnt = q_reg[i].cnt - 1'b1;
    end
    q_next     = aged;
    valid_next = valid_reg;
    if (pop) begin
      q_next[0]     = aged[1];
      valid_next[0] = valid_reg[1];
      valid_next[1] = 1'b0;
    end
    if (push) begin
      if (!valid_next[0]) begin
        q_next[0]     = push_entry;
        valid_next[0] = 1'b1;
      end else begin
        q_next[1]     = push_entry;
        valid_next[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      for (int i = 0; i < QDEPTH; i++) q_reg[i] <= '0;
    end else begin
      valid_reg <= valid_next;
      for (int i = 0; i < QDEPTH; i++) q_reg[i] <= q_next[i];
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// Memory end of the CPU data sram-like port: byte-lane RAM, address handshake and fixed-latency responses.
module dsram_responder
  import dsram_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic [31:0]       rd_word;
  logic              head_ready;
  logic              head_is_wr;
  logic [31:0]       head_data;
  logic [OCC_W-1:0]  occupancy;
  logic              unused_bits;

  assign idx               = data_sram_addr[ADDR_W+1:2];
  assign data_sram_addr_ok = !reset && (occupancy < OCC_W'(QDEPTH));
  assign accept            = data_sram_req && data_sram_addr_ok;

  // Size and the aliased/sub-word address bits carry no meaning here.
  assign unused_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0],
                         data_sram_size == SIZE_BYTE, data_sram_size == SIZE_HALF,
                         data_sram_size == SIZE_WORD};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (accept && data_sram_wr && data_sram_wstrb[gi])
          lane_mem[idx] <= data_sram_wdata[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = lane_mem[idx];
    end
  endgenerate

  // The queue entry register doubles as the read register: data is captured at acceptance.
  resp_fifo #(
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_is_wr (data_sram_wr),
    .push_data  (data_sram_wr ? 32'd0 : rd_word),
    .head_ready (head_ready),
    .head_is_wr (head_is_wr),
    .head_data  (head_data),
    .occupancy  (occupancy)
  );

  assign data_sram_data_ok = !reset && head_ready;
  assign data_sram_rdata   = (data_sram_data_ok && !head_is_wr) ? head_data : 32'd0;

endmodule
